// File: rtl/multipli_shift_add_if.sv
// Operand/result bundle for the Booth shift-add multiplier.
// The master drives a request; the slave returns the signed product and its valid flag.
interface multipli_shift_add_if #(parameter int size = 8);
  logic                START;
  logic [size-1:0]     A;
  logic [size-1:0]     B;
  logic [2*size-1:0]   S;
  logic                END_MULT;

  modport master (output START, A, B, input  S, END_MULT);
  modport slave  (input  START, A, B, output S, END_MULT);
endinterface

// File: rtl/multipli_shift_add.sv
// Radix-2 Booth signed multiplier, one add/shift iteration per clock.
// IDLE loads operands, OP iterates size times, DONE holds the product until START drops.
module multipli_shift_add #(
  parameter int size = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  multipli_shift_add_if.slave  bus
);
  localparam int CW = $clog2(size + 1);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t                r_state;
  logic signed [size:0]  r_acc;
  logic [size-1:0]       r_m;
  logic [size-1:0]       r_q;
  logic                  r_qm1;
  logic [CW-1:0]         r_cnt;
  logic [2*size-1:0]     r_s;
  logic                  r_end;

  logic signed [size:0]  w_m_ext;
  logic signed [size:0]  w_sum;

  // One extra accumulator bit keeps Acc-M exact when M is the most negative value.
  assign w_m_ext = {r_m[size-1], r_m};

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_end   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_end <= 1'b0;
          if (bus.START) begin
            r_m     <= bus.A;
            r_q     <= bus.B;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= CW'(size);
            r_state <= OP;
          end
        end
        OP: begin
          if (r_cnt == '0) begin
            r_s     <= {r_acc[size-1:0], r_q};
            r_end   <= 1'b1;
            r_state <= DONE;
          end else begin
            // Arithmetic shift of {Acc,Q,q_m1}: old Q[0] becomes q_m1.
            {r_acc, r_q, r_qm1} <= {w_sum[size], w_sum, r_q};
            r_cnt               <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (!bus.START) begin
            r_end   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.S        = r_s;
  assign bus.END_MULT = r_end;
endmodule

// File: tb/tb_multipli_shift_add.sv
// Scoreboard bench for multipli_shift_add: expected products queued at request time,
// popped and compared when END_MULT rises.
module tb_multipli_shift_add;
  localparam int SZ = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multipli_shift_add_if #(.size(SZ)) bus ();
  multipli_shift_add #(.size(SZ)) dut (.CLOCK(clk), .RESET(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [2*SZ-1:0] sb[$];
  logic [2*SZ-1:0] last_s;
  logic [15:0] cov_a, cov_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*SZ-1:0] ref_mul(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    logic signed [2*SZ-1:0] ea, eb, p;
    ea = $signed({{SZ{a[SZ-1]}}, a});
    eb = $signed({{SZ{b[SZ-1]}}, b});
    p  = ea * eb;
    return p;
  endfunction

  // Request a product, scramble A/B while it runs, then hold START for 'hold' cycles in DONE.
  task automatic do_op(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input int hold);
    int n;
    logic got;
    logic [2*SZ-1:0] exp;
    @(negedge clk);
    rst = 1'b0; bus.A = a; bus.B = b; bus.START = 1'b1;
    sb.push_back(ref_mul(a, b));
    got = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.END_MULT) begin got = 1'b1; break; end
      chk("s_stable_in_op", bus.S, last_s);
      bus.A = SZ'($urandom); bus.B = SZ'($urandom);
    end
    exp = sb.pop_front();
    if (!got) chk("end_mult_timeout", 0, 1);
    else begin
      chk("latency_edges", n, SZ + 2);
      chk("product", bus.S, exp);
    end
    last_s = exp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("done_hold_end", bus.END_MULT, 1);
      chk("done_hold_s", bus.S, last_s);
    end
    @(negedge clk); bus.START = 1'b0;
    @(posedge clk); #1;
    chk("end_low_idle", bus.END_MULT, 0);
    @(posedge clk); #1;
    chk("idle_s_kept", bus.S, last_s);
    chk("idle_end_low", bus.END_MULT, 0);
  endtask

  initial begin
    logic [SZ-1:0] ra, rb;
    rst = 1'b1; bus.START = 1'b1; bus.A = 8'd9; bus.B = 8'd9;
    last_s = '0; cov_a = '0; cov_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", bus.S, 0);
    chk("rst_end", bus.END_MULT, 0);

    // Reset released with START high: fresh operation begins.
    do_op(8'd3, 8'd5, 0);        chk("3x5", bus.S, 16'h000F);
    do_op(8'h80, 8'h80, 0);      chk("m128xm128", bus.S, 16'h4000);
    do_op(8'h80, 8'd127, 0);     chk("m128x127", bus.S, 16'hC080);
    do_op(8'hFF, 8'd1, 0);       chk("m1x1", bus.S, 16'hFFFF);
    do_op(8'd0, 8'hB3, 0);       chk("0xm77", bus.S, 16'h0000);
    do_op(8'd127, 8'h80, 20);    chk("hold20", bus.S, 16'hC080);
    do_op(8'd11, 8'd13, 0);      chk("after_hold", bus.S, 16'd143);

    // Abort mid-OP with reset, then 7 * -3 from a START kept high through reset.
    @(negedge clk); bus.A = 8'd5; bus.B = 8'd9; bus.START = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1; bus.A = 8'd7; bus.B = 8'hFD;
    @(posedge clk); #1;
    chk("abort_s", bus.S, 0);
    chk("abort_end", bus.END_MULT, 0);
    last_s = '0;
    @(posedge clk); #1;
    chk("abort_end2", bus.END_MULT, 0);
    do_op(8'd7, 8'hFD, 0);       chk("7xm3", bus.S, 16'hFFEB);

    for (int k = 0; k < 200; k++) begin
      ra = SZ'($urandom); rb = SZ'($urandom);
      cov_a[ra[SZ-1:SZ-4]] = 1'b1;
      cov_b[rb[SZ-1:SZ-4]] = 1'b1;
      do_op(ra, rb, 0);
    end
    chk("cov_a_90pct", ($countones(cov_a) >= 15), 1);
    chk("cov_b_90pct", ($countones(cov_b) >= 15), 1);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
